// File: rtl/req_capture_4_if.sv
// Request-capture bus: raw request/mask/clear controls in, pending/overflow/count status out.
interface req_capture_4_if;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic       clr_valid;
  logic [1:0] clr_id;
  logic       ovf_clr;
  logic [3:0] pending;
  logic       any_pending;
  logic [3:0] overflow;
  logic [7:0] event_count;

  modport master (
    output req_in, mask, clr_valid, clr_id, ovf_clr,
    input  pending, any_pending, overflow, event_count
  );

  modport slave (
    input  req_in, mask, clr_valid, clr_id, ovf_clr,
    output pending, any_pending, overflow, event_count
  );
endinterface

// File: rtl/req_capture_4.sv
// Four-channel asynchronous request capture: synchronize, detect edge/level, latch
// into a pending vector with per-channel overflow flags and a saturating event count.
module req_capture_4 #(
  parameter int EDGE_MODE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  req_capture_4_if.slave  bus
);

  logic [3:0] r_sync1;
  logic [3:0] r_req_s;
  logic [3:0] r_req_d;
  logic [3:0] r_pending;
  logic [3:0] r_overflow;
  logic [7:0] r_event_count;

  logic [3:0] w_set;
  logic [3:0] w_acc;
  logic [3:0] w_clr_hit;
  logic [3:0] w_ovf_hit;
  logic [3:0] w_pending_nxt;
  logic [3:0] w_overflow_nxt;
  logic [7:0] w_count_nxt;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {6'b000000, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Stage: two-flop synchronizer plus the delay flop used for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 4'b0000;
      r_req_s <= 4'b0000;
      r_req_d <= 4'b0000;
    end else begin
      r_sync1 <= bus.req_in;
      r_req_s <= r_sync1;
      r_req_d <= r_req_s;
    end
  end

  // Stage: event qualification and next-state of the capture registers
  always_comb begin
    w_set          = (EDGE_MODE != 0) ? (r_req_s & ~r_req_d) : r_req_s;
    w_acc          = w_set & ~bus.mask;
    w_clr_hit      = bus.clr_valid ? (4'b0001 << bus.clr_id) : 4'b0000;
    // An accept colliding with a clear of the same bit is a hand-off, not a lost event
    w_ovf_hit      = w_acc & r_pending & ~w_clr_hit;
    w_pending_nxt  = (r_pending & ~w_clr_hit) | w_acc;
    w_overflow_nxt = (r_overflow & ~{4{bus.ovf_clr}}) | w_ovf_hit;
    w_count_nxt    = sat_add8(r_event_count, popcount4(w_acc));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending     <= 4'b0000;
      r_overflow    <= 4'b0000;
      r_event_count <= 8'h00;
    end else begin
      r_pending     <= w_pending_nxt;
      r_overflow    <= w_overflow_nxt;
      r_event_count <= w_count_nxt;
    end
  end

  assign bus.pending     = r_pending;
  assign bus.any_pending = |r_pending;
  assign bus.overflow    = r_overflow;
  assign bus.event_count = r_event_count;

endmodule

// File: tb/tb_req_capture_4.sv
// Bench for req_capture_4: edge- and level-mode instances share one stimulus stream
// and are compared every cycle against a sample-history reference model.
module tb_req_capture_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic       clr_valid;
  logic [1:0] clr_id;
  logic       ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;

  req_capture_4_if ife ();
  req_capture_4_if ifl ();

  assign ife.req_in = req_in;   assign ifl.req_in = req_in;
  assign ife.mask = mask;       assign ifl.mask = mask;
  assign ife.clr_valid = clr_valid; assign ifl.clr_valid = clr_valid;
  assign ife.clr_id = clr_id;   assign ifl.clr_id = clr_id;
  assign ife.ovf_clr = ovf_clr; assign ifl.ovf_clr = ovf_clr;

  req_capture_4 #(.EDGE_MODE(1)) u_edge (.clk(clk), .rst_n(rst_n), .bus(ife));
  req_capture_4 #(.EDGE_MODE(0)) u_lvl  (.clk(clk), .rst_n(rst_n), .bus(ifl));

  always #5 clk = ~clk;

  // Reference: samp[k] is req_in as sampled k+1 edges ago (zero after reset).
  logic [3:0] samp [0:2];
  logic [3:0] m_pend [0:1];
  logic [3:0] m_ovf  [0:1];
  int         m_cnt  [0:1];

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] s, d, set, acc, hit;
    int n;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = 4'b0000; m_ovf[m] = 4'b0000; m_cnt[m] = 0;
      end
      for (int k = 0; k < 3; k++) samp[k] = 4'b0000;
    end else begin
      s = samp[1];
      d = samp[2];
      hit = 4'b0000;
      if (clr_valid) hit[clr_id] = 1'b1;
      for (int m = 0; m < 2; m++) begin
        set = (m == 0) ? (s & ~d) : s;
        acc = set & ~mask;
        m_ovf[m] = (ovf_clr ? 4'b0000 : m_ovf[m]) | (acc & m_pend[m] & ~hit);
        m_pend[m] = (m_pend[m] & ~hit) | acc;
        n = $countones(acc);
        m_cnt[m] = (m_cnt[m] + n > 255) ? 255 : m_cnt[m] + n;
      end
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = req_in;
    end
  endtask

  task automatic compare_all();
    chk("e.pending",  32'(ife.pending),     32'(m_pend[0]));
    chk("e.any",      32'(ife.any_pending), 32'(|m_pend[0]));
    chk("e.overflow", 32'(ife.overflow),    32'(m_ovf[0]));
    chk("e.count",    32'(ife.event_count), 32'(m_cnt[0]));
    chk("l.pending",  32'(ifl.pending),     32'(m_pend[1]));
    chk("l.any",      32'(ifl.any_pending), 32'(|m_pend[1]));
    chk("l.overflow", 32'(ifl.overflow),    32'(m_ovf[1]));
    chk("l.count",    32'(ifl.event_count), 32'(m_cnt[1]));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  initial begin
    rst_n = 1'b0; req_in = 4'b0000; mask = 4'b0000;
    clr_valid = 1'b0; clr_id = 2'd0; ovf_clr = 1'b0;
    for (int k = 0; k < 3; k++) samp[k] = 4'b0000;
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = 4'b0000; m_ovf[m] = 4'b0000; m_cnt[m] = 0;
    end
    #2;
    step(2);
    chk("rst.pending",  32'(ife.pending),     32'h0);
    chk("rst.any",      32'(ife.any_pending), 32'h0);
    chk("rst.overflow", 32'(ife.overflow),    32'h0);
    chk("rst.count",    32'(ife.event_count), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Single held pulse: three-edge latency, one event in edge mode
    req_in = 4'b0100;
    step(3);
    chk("lat.pending", 32'(ife.pending),     32'h4);
    chk("lat.any",     32'(ife.any_pending), 32'h1);
    chk("lat.count",   32'(ife.event_count), 32'h1);
    step(4);
    chk("held.count",  32'(ife.event_count), 32'h1);

    // Clear of bit 3, then bit 2
    req_in = 4'b1100;
    step(3);
    chk("b3.pending", 32'(ife.pending), 32'hC);
    clr_valid = 1'b1; clr_id = 2'd3;
    step(1);
    chk("clr3.pending", 32'(ife.pending), 32'h4);
    clr_id = 2'd2;
    step(1);
    clr_valid = 1'b0;
    chk("clr2.pending", 32'(ife.pending),     32'h0);
    chk("clr2.any",     32'(ife.any_pending), 32'h0);

    // Second edge on a pending bit raises overflow; ovf_clr drops it
    req_in = 4'b0000; step(2);
    req_in = 4'b0010; step(3);
    req_in = 4'b0000; step(2);
    req_in = 4'b0010; step(3);
    chk("ovf.flag",    32'(ife.overflow), 32'h2);
    chk("ovf.pending", 32'(ife.pending),  32'h2);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    chk("ovfclr.flag", 32'(ife.overflow), 32'h0);

    // Accept and clear colliding on bit 2 while it is already pending
    req_in = 4'b0100; step(3);
    req_in = 4'b0000; step(2);
    req_in = 4'b0100; step(2);
    clr_valid = 1'b1; clr_id = 2'd2;
    step(1);
    clr_valid = 1'b0;
    chk("coll.pending2", 32'(ife.pending[2]),  32'h1);
    chk("coll.ovf2",     32'(ife.overflow[2]), 32'h0);

    // Fully masked edges, then level-mode saturation
    mask = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_in = 4'b1111; step(2);
      req_in = 4'b0000; step(2);
    end
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    mask = 4'b0000; req_in = 4'b1111;
    step(70);
    chk("sat.count",    32'(ifl.event_count), 32'd255);
    chk("sat.overflow", 32'(ifl.overflow),    32'hF);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      if (($urandom_range(0, 3)) == 0) req_in = 4'($urandom);
      if (($urandom_range(0, 15)) == 0) mask = 4'($urandom) & 4'($urandom);
      clr_valid = ($urandom_range(0, 2) == 0);
      clr_id    = 2'($urandom);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      step(1);
    end
    rst_n = 1'b1; clr_valid = 1'b0; ovf_clr = 1'b0; mask = 4'b0000;

    // Mid-operation reset with a clear strobe present
    req_in = 4'b1011; step(3);
    req_in = 4'b0000; step(2);
    clr_valid = 1'b1; clr_id = 2'd0; rst_n = 1'b0;
    step(1);
    chk("mrst.pending",  32'(ife.pending),     32'h0);
    chk("mrst.any",      32'(ife.any_pending), 32'h0);
    chk("mrst.overflow", 32'(ife.overflow),    32'h0);
    chk("mrst.count",    32'(ife.event_count), 32'h0);
    clr_valid = 1'b0;

    // Request held high through reset release is captured once in edge mode
    req_in = 4'b0001; step(2);
    rst_n = 1'b1;
    step(5);
    chk("relhold.count", 32'(ife.event_count), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/req_capture_4.md
REQ_CAPTURE_4 -- requirements
Module: req_capture_4

Interface
REQ-001 Parameter: EDGE_MODE, default 1; 1 = capture rising edges of req_in, 0 = capture while req_in is high (level).
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all flops.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req_in  input  4  asynchronous request sources; bit 3 is highest priority downstream.
REQ-006 mask  input  4  per-channel mask, synchronous to clk; 1 = discard events.
REQ-007 clr_valid  input  1  single-cycle clear strobe from the downstream consumer.
REQ-008 clr_id  input  2  index of the pending bit to clear, qualified by clr_valid.
REQ-009 ovf_clr  input  1  clears all overflow flags.
REQ-010 pending  output  4  latched request vector; feeds the 4:2 priority encoder input.
REQ-011 any_pending  output  1  OR of pending; equals the encoder valid.
REQ-012 overflow  output  4  sticky per-channel lost-event flags.
REQ-013 event_count  output  8  saturating count of accepted events.

Function
REQ-014 Each req_in bit SHALL pass through a 2-flop synchronizer: sync1, then req_s.
REQ-015 A delay flop SHALL hold req_d, the previous req_s.
REQ-016 The set term SHALL be set[i] = req_s[i] & ~req_d[i] when EDGE_MODE=1, and req_s[i] when EDGE_MODE=0.
REQ-017 The accepted term SHALL be acc[i] = set[i] & ~mask[i]; masked events are dropped, never pended and never flagged as overflow.
REQ-018 The clear term SHALL be clr_hit[i] = clr_valid & (clr_id == i); clr_valid with a non-pending target is a no-op.
REQ-019 The pending update SHALL be pending[i] <= (pending[i] & ~clr_hit[i]) | acc[i].
REQ-020 When clear and accept hit the same bit in one cycle, accept SHALL win: pending stays 1 and no overflow is raised.
REQ-021 overflow[i] SHALL set when acc[i] is 1, pending[i] is 1 and clr_hit[i] is 0 in the same cycle.
REQ-022 ovf_clr SHALL zero overflow; a new overflow condition in the same cycle SHALL win for that bit.
REQ-023 Mask changes SHALL NOT alter bits already pending.
REQ-024 event_count SHALL add popcount(acc) (0..4) per cycle, saturating at 255 with no wrap; an addition that would exceed 255 yields 255.
REQ-025 Latency: with req_in high before edge k, pending[i] SHALL be 1 after edge k+2, i.e. 3 edges; event_count updates on the same edge.
REQ-026 In EDGE_MODE=1, a held-high req_in SHALL produce exactly one event; a new event requires a low pulse of at least 2 clk cycles.
REQ-027 In EDGE_MODE=0, an unmasked held-high req_in SHALL re-set pending each cycle, and overflow rules apply every cycle.
REQ-028 any_pending SHALL be combinational from pending, with no extra latency.

Reset
REQ-029 While rst_n=0 at a clk edge, sync1, req_s, req_d, pending, overflow and event_count SHALL all load 0.
REQ-030 Reset asserted mid-operation SHALL discard all pending bits, overflow flags and counts on that edge; clear strobes in that cycle are ignored.
REQ-031 A req_in held high through reset release SHALL be captured as one event in EDGE_MODE=1, because req_d resets to 0.

Verification
REQ-032 EDGE_MODE=1, mask=0, pulse req_in=4'b0100 for 3 cycles -> pending=4'b0100 and any_pending=1 after the 3rd edge; event_count=1; no further events while held.
REQ-033 pending=4'b1000, then clr_valid=1, clr_id=3 -> pending=4'b0000 next edge; any_pending=0.
REQ-034 pending[1]=1, a second req_in[1] edge arrives with no clear -> overflow=4'b0010 and pending unchanged; ovf_clr=1 -> overflow=0.
REQ-035 An accepted edge on bit 2 and clr_id=2 hit the same cycle -> pending[2]=1 and overflow[2]=0.
REQ-036 mask=4'b1111 with edges on all bits -> pending=0, overflow=0, event_count unchanged; then EDGE_MODE=0, mask=0, req_in=4'hF held for 70 cycles -> event_count saturates at 255 and overflow=4'hF.
REQ-037 Assert rst_n=0 for one edge with pending=4'b1011 and event_count=17 -> all outputs 0 on that edge.
